tx_funcmod: RTL
===============

TX_FUNCMOD -- requirements
Module: tx_funcmod

Interface
REQ-001 Parameter BAUD_DIV, default 434, clocks per bit (115200 baud at 50 MHz); legal 2..65535.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal 5..8.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; legal 1 or 2.
REQ-005 CLOCK  input  1  sole clock; all state changes on its rising edge.
REQ-006 RESET  input  1  asynchronous, active-high reset.
REQ-007 iCall  input  1  transmit request; held high by caller until oDone is seen.
REQ-008 iData  input  8  byte to send; bits [DATA_BITS-1:0] used, upper bits ignored.
REQ-009 oDone  output 1  one-cycle pulse: frame fully shifted out.
REQ-010 TXD    output 1  serial line, idle high.

Function
REQ-011 FSM states SHALL be IDLE, START, DATA, PARITY, STOP, DONE.
REQ-012 IDLE: TXD=1, oDone=0; on iCall=1, latch iData into shift register, clear bit index and baud counter, go to START next cycle.
REQ-013 START: TXD=0 for exactly BAUD_DIV cycles.
REQ-014 DATA: TXD=shift[0] for BAUD_DIV cycles per bit, LSB first; DATA_BITS bits total, then PARITY if PARITY!=0, else STOP.
REQ-015 PARITY: TXD = XOR of the DATA_BITS sent (even) or its inverse (odd), for BAUD_DIV cycles.
REQ-016 STOP: TXD=1 for STOP_BITS*BAUD_DIV cycles, then DONE.
REQ-017 DONE: TXD=1, oDone=1 for exactly one cycle, then IDLE unconditionally.
REQ-018 Baud counter SHALL count 0..BAUD_DIV-1 and wrap to 0 at each bit boundary; width 16 bits.
REQ-019 TXD and oDone SHALL be driven from registers (no combinational path from inputs).
REQ-020 iData changes after latch SHALL NOT affect the frame in progress.
REQ-021 iCall deassertion mid-frame SHALL NOT abort the frame; frame completes and oDone still pulses.
REQ-022 Caller drops iCall on the cycle after sampling oDone; if iCall is still high in IDLE a new frame starts (back-to-back legal, one idle-high cycle between stop and next start).
REQ-023 Latency: iCall sampled high in IDLE at cycle T -> TXD falls at T+1; oDone high at T+1+BAUD_DIV*(1+DATA_BITS+P+STOP_BITS), P=1 if PARITY!=0 else 0.

Reset
REQ-024 While RESET=1: state=IDLE, TXD=1, oDone=0, baud counter=0, bit index=0, shift register=0.
REQ-025 RESET asserted mid-frame SHALL force TXD=1 immediately (asynchronously) and discard the frame; no oDone.
REQ-026 After RESET release, first frame may start on the first rising edge with iCall=1.

Structure
REQ-027 Shared package uart_pkg SHALL hold baud constants (B115K2=434, B9600=5208 at 50 MHz), parity encodings (PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2) and the FSM state encoding.
REQ-028 Baud counter SHALL be one sub-module, bps_tick (enable/clear in, bit-end tick out), shared with rx_funcmod.
REQ-029 Elaboration SHALL reject illegal BAUD_DIV, DATA_BITS, PARITY or STOP_BITS values.

Verification
REQ-030 Defaults, iCall=1 with iData=8'h55 -> TXD 0,1,0,1,0,1,0,1,0,1 each 434 cycles; oDone at T+1+4340.
REQ-031 PARITY=2, iData=8'h07 -> parity bit 1; PARITY=1 same byte -> parity bit 0; oDone at T+1+4774.
REQ-032 STOP_BITS=2, BAUD_DIV=4, iData=8'hA3, iCall held high through oDone -> stop high 8 cycles, oDone one cycle, one idle cycle, second start bit follows.
REQ-033 DATA_BITS=5, BAUD_DIV=4, iData=8'hFF -> exactly 5 data bits of 1, then stop; oDone at T+1+28.
REQ-034 RESET pulsed during DATA bit 3 -> TXD=1 within the same cycle, no oDone, next iCall transmits a full correct frame.
REQ-035 iData changed and iCall dropped mid-frame -> transmitted byte equals latched value; oDone still pulses once.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants, parity encodings and transmitter state encoding.
// Used by both the transmit and receive function modules.
package uart_pkg;

    localparam int B115K2 = 434;   // clocks per bit at 50 MHz
    localparam int B9600  = 5208;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } tx_state_e;

    // XOR of the low n bits of d.
    function automatic logic xor_bits(input logic [7:0] d, input int n);
        logic p;
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < n) p = p ^ d[i];
        end
        return p;
    endfunction

endpackage

// File: rtl/tx_funcmod_if.sv
// Caller-side handshake and serial line of the UART transmitter.
// The caller is the master; tx_funcmod is the slave.
interface tx_funcmod_if;
    logic       iCall;
    logic [7:0] iData;
    logic       oDone;
    logic       TXD;

    modport master (output iCall, output iData, input oDone, input TXD);
    modport slave  (input iCall, input iData, output oDone, output TXD);
endinterface

// File: rtl/bps_tick.sv
// Bit-period counter: counts 0..BAUD_DIV-1 while enabled and flags the last
// cycle of each bit. Shared between the UART transmitter and receiver.
module bps_tick #(
    parameter int BAUD_DIV = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tick_o
);
    localparam logic [15:0] LAST = 16'(BAUD_DIV - 1);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? 16'd0 : cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/tx_funcmod.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity,
// STOP_BITS stop bits, then a one-cycle oDone pulse. TXD and oDone are registered.
module tx_funcmod
    import uart_pkg::*;
#(
    parameter int BAUD_DIV  = B115K2,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = PAR_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic         CLOCK,
    input  logic         RESET,
    tx_funcmod_if.slave  bus
);
    generate
        if (BAUD_DIV < 2 || BAUD_DIV > 65535 || DATA_BITS < 5 || DATA_BITS > 8 ||
            PARITY < PAR_NONE || PARITY > PAR_EVEN || STOP_BITS < 1 || STOP_BITS > 2)
        begin : g_bad_param
            $error("tx_funcmod: illegal BAUD_DIV, DATA_BITS, PARITY or STOP_BITS");
        end
    endgenerate

    tx_state_e  state_q;
    logic [7:0] shift_q;
    logic [2:0] bit_idx_q;
    logic       par_q;
    logic       txd_q;
    logic       done_q;
    logic       tick;
    logic       bit_en;
    logic       last_data;
    logic       last_stop;

    assign bit_en    = (state_q == S_START) || (state_q == S_DATA) ||
                       (state_q == S_PARITY) || (state_q == S_STOP);
    assign last_data = (bit_idx_q == 3'(DATA_BITS - 1));
    assign last_stop = (bit_idx_q == 3'(STOP_BITS - 1));

    bps_tick #(.BAUD_DIV(BAUD_DIV)) u_bps (
        .clk    (CLOCK),
        .rst    (RESET),
        .en_i   (bit_en),
        .clr_i  (!bit_en),
        .tick_o (tick)
    );

    // Outputs are loaded with the value of the state being entered, so the
    // line changes on the same edge as the state.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            shift_q   <= '0;
            bit_idx_q <= '0;
            par_q     <= 1'b0;
            txd_q     <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    txd_q <= 1'b1;
                    if (bus.iCall) begin
                        shift_q   <= bus.iData;
                        bit_idx_q <= '0;
                        par_q     <= xor_bits(bus.iData, DATA_BITS) ^ (PARITY == PAR_ODD);
                        txd_q     <= 1'b0;
                        state_q   <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        txd_q   <= shift_q[0];
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (tick) begin
                        if (last_data) begin
                            bit_idx_q <= '0;
                            if (PARITY != PAR_NONE) begin
                                txd_q   <= par_q;
                                state_q <= S_PARITY;
                            end else begin
                                txd_q   <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            shift_q   <= shift_q >> 1;
                            bit_idx_q <= bit_idx_q + 3'd1;
                            txd_q     <= shift_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        txd_q   <= 1'b1;
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (last_stop) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    txd_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.TXD   = txd_q;
    assign bus.oDone = done_q;
endmodule
